div_unit: RTL

Multi-cycle 32-bit integer divider serving the MIPS `div` and `divu` instructions. The control unit's HI/LO select encoding distinguishes `div` (2) from `divu` (3). The datapath converts that select into a `start` pulse plus `is_signed`. This block returns the quotient for LO and the remainder for HI, with a busy/done handshake that the pipeline uses to stall `mfhi`/`mflo`.

---
 rtl/div_unit.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/div_unit.sv
// div_unit: multi-cycle restoring divider for MIPS div/divu.
// Returns the quotient (to LO) and remainder (to HI) 33 cycles after an accepted
// start, with a busy/done handshake used to stall mfhi/mflo.
// Ports:
//   i_clk, i_rst         clock, synchronous active-high reset
//   i_start, i_is_signed request a divide; 1 = signed (div), 0 = unsigned (divu)
//   i_flush              abort an in-flight divide, no done
//   i_dividend, i_divisor operands, sampled with an accepted start
//   o_busy, o_done       divide in progress / one-cycle result-valid pulse
//   o_quotient, o_remainder, o_div_by_zero  results, held until the next done
module div_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic             i_is_signed,
  input  logic             i_flush,
  input  logic [WIDTH-1:0] i_dividend,
  input  logic [WIDTH-1:0] i_divisor,
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_quotient,
  output logic [WIDTH-1:0] o_remainder,
  output logic             o_div_by_zero
);

  localparam int unsigned CW = 5;
  localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIN  = 2'd2
  } state_t;

  state_t           r_state, w_state_nxt;
  logic [CW-1:0]    r_cnt, w_cnt_nxt;
  logic             w_accept, w_iter, w_finish;

  logic [WIDTH-1:0] r_q, r_rem, r_dvs;
  logic             r_q_neg, r_rem_neg, r_dbz;
  logic             r_busy, r_done, r_dbz_out;
  logic [WIDTH-1:0] r_quo_out, r_rem_out;

  logic             w_dbz;
  logic [WIDTH-1:0] w_a_mag, w_b_mag;
  logic [WIDTH:0]   w_shift;
  logic [WIDTH+1:0] w_sub;

  // State and iteration counter
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Next state; start coinciding with flush is dropped even when idle
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_accept    = 1'b0;
    w_iter      = 1'b0;
    w_finish    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_start && !i_flush) begin
          w_state_nxt = S_RUN;
          w_cnt_nxt   = '0;
          w_accept    = 1'b1;
        end
      end
      S_RUN: begin
        if (i_flush) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_iter    = 1'b1;
          w_cnt_nxt = r_cnt + CW'(1);
          if (r_cnt == LAST_ITER) w_state_nxt = S_FIN;
        end
      end
      S_FIN: begin
        w_state_nxt = S_IDLE;
        w_finish    = !i_flush;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Operand magnitudes; a zero divisor keeps the raw dividend so that the
  // iterations (every trial subtract succeeds) leave q = all ones, rem = dividend
  assign w_dbz   = (i_divisor == '0);
  assign w_a_mag = (i_is_signed && i_dividend[WIDTH-1] && !w_dbz) ? -i_dividend : i_dividend;
  assign w_b_mag = (i_is_signed && i_divisor[WIDTH-1])  ? -i_divisor  : i_divisor;

  // One restoring step: shift {rem,q} left, trial-subtract the divisor magnitude
  assign w_shift = {r_rem, r_q[WIDTH-1]};
  assign w_sub   = {1'b0, w_shift} - {2'b00, r_dvs};

  // Datapath and registered outputs
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_q       <= '0;
      r_rem     <= '0;
      r_dvs     <= '0;
      r_q_neg   <= 1'b0;
      r_rem_neg <= 1'b0;
      r_dbz     <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_quo_out <= '0;
      r_rem_out <= '0;
      r_dbz_out <= 1'b0;
    end else begin
      r_busy <= (w_state_nxt != S_IDLE);
      r_done <= w_finish;
      if (w_accept) begin
        r_q       <= w_a_mag;
        r_rem     <= '0;
        r_dvs     <= w_b_mag;
        r_q_neg   <= i_is_signed && (i_dividend[WIDTH-1] ^ i_divisor[WIDTH-1]) && !w_dbz;
        r_rem_neg <= i_is_signed && i_dividend[WIDTH-1] && !w_dbz;
        r_dbz     <= w_dbz;
      end else if (w_iter) begin
        // Successful subtract result is below the divisor, so it fits in WIDTH bits
        r_rem <= w_sub[WIDTH+1] ? w_shift[WIDTH-1:0] : w_sub[WIDTH-1:0];
        r_q   <= {r_q[WIDTH-2:0], ~w_sub[WIDTH+1]};
      end
      if (w_finish) begin
        r_quo_out <= r_q_neg   ? -r_q   : r_q;
        r_rem_out <= r_rem_neg ? -r_rem : r_rem;
        r_dbz_out <= r_dbz;
      end
    end
  end

  assign o_busy        = r_busy;
  assign o_done        = r_done;
  assign o_quotient    = r_quo_out;
  assign o_remainder   = r_rem_out;
  assign o_div_by_zero = r_dbz_out;

endmodule
